// File: rtl/pc.sv
// -----------------------------------------------------------------------------
// pc -- program counter register for the KLP32 RV32I core.
//
// Holds the address of the instruction currently being fetched. A new next-PC
// value is captured from the PC-select logic on every rising clock edge; there
// is no enable, so stalls are made upstream by feeding pc_out back into pc_in.
// The sequential fall-through address (pc_out + 4) is also produced here for
// the next-PC mux.
//
// Parameters
//   N             address width in bits (N >= 3)
//   RESET_VECTOR  value loaded into pc_out while reset is asserted
//
// Ports
//   clk         in   1  system clock, rising edge active
//   reset       in   1  synchronous, active-high reset
//   pc_in       in   N  next-PC value, captured every rising edge
//   pc_out      out  N  current PC (registered)
//   pc_plus4    out  N  pc_out + 4, wraps modulo 2^N, no carry-out
//   misaligned  out  1  registered pc_out[1:0] != 0 flag (see macro below)
//
// Configuration macro
//   PC_ALIGN_CHECK_EN  when defined, misaligned is a flop that updates on the
//                      same edge as pc_out and clears on reset (RESET_VECTOR
//                      is assumed to be word-aligned). When undefined,
//                      misaligned is tied low and no extra flop exists.
//                      The port list is the same in both builds.
// -----------------------------------------------------------------------------
module pc #(
  parameter int         N            = 32,
  parameter logic [N-1:0] RESET_VECTOR = {N{1'b0}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] pc_in,
  output logic [N-1:0] pc_out,
  output logic [N-1:0] pc_plus4,
  output logic         misaligned
);

  // Sequential instruction step; built from sized pieces so it tracks N.
  localparam logic [N-1:0] PC_STEP = {{(N-3){1'b0}}, 3'b100};

  logic [N-1:0] pc_r;

  // PC register: reset vector on reset, otherwise load pc_in unmodified.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= RESET_VECTOR;
    end else begin
      pc_r <= pc_in;
    end
  end

  assign pc_out = pc_r;

  // Fall-through address; carry out of bit N-1 is discarded so it wraps.
  assign pc_plus4 = pc_r + PC_STEP;

`ifdef PC_ALIGN_CHECK_EN
  logic misaligned_r;

  // Alignment flag: computed from the value being loaded so it lines up
  // with pc_out on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      misaligned_r <= 1'b0;
    end else begin
      misaligned_r <= (pc_in[1:0] != 2'b00);
    end
  end

  assign misaligned = misaligned_r;
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_pc.sv
// -----------------------------------------------------------------------------
// tb_pc -- self-checking bench for the pc register.
// Expected results are pushed to a queue when stimulus is applied and popped
// and compared after the rising edge that should produce them.
// -----------------------------------------------------------------------------
module tb_pc;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        misaligned;

  int checks;
  int errors;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] plus4;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];

  pc #(.N(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc_in),
    .pc_out     (pc_out),
    .pc_plus4   (pc_plus4),
    .misaligned (misaligned)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model of what the next edge must produce.
  function automatic exp_t model(input logic rst, input logic [31:0] din);
    exp_t e;
    e.pc    = rst ? 32'h0000_0000 : din;
    e.plus4 = e.pc + 32'd4;
`ifdef PC_ALIGN_CHECK_EN
    e.mis   = rst ? 1'b0 : (din[1:0] != 2'b00);
`else
    e.mis   = 1'b0;
`endif
    return e;
  endfunction

  // Apply inputs at the falling edge and record what the next rising edge owes.
  task automatic drive(input logic rst, input logic [31:0] din);
    @(negedge clk);
    reset = rst;
    pc_in = din;
    exp_q.push_back(model(rst, din));
  endtask

  // Wait for the rising edge, then compare against the oldest expectation.
  task automatic expect_edge(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got empty scoreboard expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".pc"}, pc_out, e.pc);
      check({tag, ".plus4"}, pc_plus4, e.plus4);
      check({tag, ".mis"}, {31'd0, misaligned}, {31'd0, e.mis});
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic [31:0] din);
    drive(rst, din);
    expect_edge(tag);
  endtask

  initial begin
    logic [31:0] r;
    logic        rr;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    pc_in  = 32'h0000_0000;

    // 1: reset wins over pc_in
    step("reset", 1'b1, 32'h1234_5678);

    // 2: plain loads
    step("load1", 1'b0, 32'h0051_0193);
    step("load2", 1'b0, 32'h0010_0093);

    // 3: pc_in changes (with a glitch) between edges; not visible until edge
    step("hold_a", 1'b0, 32'h0010_0093);
    @(negedge clk);
    pc_in = 32'h7676_7676;
    #1 pc_in = 32'h0000_0003;
    #1 pc_in = 32'h7676_7676;
    exp_q.push_back(model(1'b0, 32'h7676_7676));
    #1;
    check("hold_mid", pc_out, 32'h0010_0093);
    expect_edge("hold_b");

    // 4: wrap of pc_plus4
    step("wrap", 1'b0, 32'hFFFF_FFFC);

    // 5: reset asserted mid-cycle only acts at the next edge
    step("pre_rst", 1'b0, 32'h0000_0040);
    @(negedge clk);
    #2 reset = 1'b1;
    exp_q.push_back(model(1'b1, pc_in));
    #1;
    check("rst_mid", pc_out, 32'h0000_0040);
    expect_edge("rst_edge");

    // 6: alignment flag set then cleared
    step("mis_set", 1'b0, 32'h0000_0042);
    step("mis_clr", 1'b0, 32'h0000_0044);
    step("mis_odd", 1'b0, 32'h0000_0001);
    step("mis_rst", 1'b1, 32'h0000_0003);

    // Stall pattern: feed pc_out back
    step("stall", 1'b0, pc_out);

    // Random traffic with occasional reset
    for (int i = 0; i < 24; i++) begin
      r  = $urandom;
      rr = ($urandom_range(0, 7) == 0);
      step("rand", rr, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
